// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared state encoding and byte/word geometry for the block memory responder.
package mem_resp_pkg;

    typedef enum logic [2:0] {IDLE, RWAIT, RBURST, WBURST, WWAIT} state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_OFF_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/mem_byte_array.sv
// mem_byte_array: byte storage with one little-endian word port, combinational read, synchronous write.
module mem_byte_array
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                            clk,
    input  logic [ADDR_W-BYTE_OFF_W-1:0]    waddr,
    input  logic                            we,
    input  logic [8*BYTES_PER_WORD-1:0]     wdata,
    output logic [8*BYTES_PER_WORD-1:0]     rdata
);

    logic [7:0] mem_q [2**ADDR_W];

    for (genvar b = 0; b < BYTES_PER_WORD; b++) begin : g_byte
        assign rdata[8*b +: 8] = mem_q[{waddr, BYTE_OFF_W'(b)}];
    end

    // Storage is deliberately outside any reset so data survives rst_n.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
                mem_q[{waddr, BYTE_OFF_W'(i)}] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/block_mem_responder.sv
// block_mem_responder: main-memory end of a cache refill/write-back link, one block request at a time.
// Define MEM_ALIGN_CHECK_EN to reject requests with nonzero block-offset bits via done+err.
module block_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W          = 10,
    parameter int DATA_W          = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int LATENCY         = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wvalid,
    output logic              wready,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              rlast,
    output logic              done,
    output logic              err
);

    localparam int BEAT_W = $clog2(WORDS_PER_BLOCK);
    localparam int OFF_W  = BEAT_W + BYTE_OFF_W;
    localparam int BLK_W  = ADDR_W - OFF_W;
    localparam int LAT_W  = $clog2(LATENCY + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_BLOCK - 1);
    localparam logic [LAT_W-1:0]  LAT_INIT  = LAT_W'(LATENCY);

    state_e              state_q;
    logic [BEAT_W-1:0]   beat_q, beat_d, beat_a;
    logic [LAT_W-1:0]    lat_q;
    logic [BLK_W-1:0]    blk_q;
    logic [DATA_W-1:0]   rdata_q, mem_rdata;
    logic                req_ready_q, wready_q, rvalid_q, rlast_q, done_q, err_q;
    logic                misaligned, we;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = |req_addr[OFF_W-1:0];
`else
    logic unused_off;
    assign misaligned = 1'b0;
    assign unused_off = ^req_addr[OFF_W-1:0];
`endif

    assign beat_d = beat_q + 1'b1;
    // During a read burst the array is addressed one beat ahead so rdata can be registered.
    assign beat_a = (state_q == RBURST) ? beat_d : beat_q;
    assign we     = (state_q == WBURST) && wvalid;

    mem_byte_array #(.ADDR_W(ADDR_W)) u_mem (
        .clk   (clk),
        .waddr ({blk_q, beat_a}),
        .we    (we),
        .wdata (wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            lat_q       <= '0;
            blk_q       <= '0;
            rdata_q     <= '0;
            req_ready_q <= 1'b1;
            wready_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            rlast_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    done_q      <= 1'b0;
                    err_q       <= 1'b0;
                    if (req_valid && req_ready_q) begin
                        blk_q       <= req_addr[ADDR_W-1:OFF_W];
                        beat_q      <= '0;
                        lat_q       <= LAT_INIT;
                        req_ready_q <= 1'b0;
                        // A rejected request stays in IDLE with ready low for its done/err cycle.
                        if (misaligned) begin
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end else begin
                            state_q  <= req_write ? WBURST : RWAIT;
                            wready_q <= req_write;
                        end
                    end
                end
                RWAIT: begin
                    if (lat_q == LAT_W'(1)) begin
                        state_q  <= RBURST;
                        rvalid_q <= 1'b1;
                        rdata_q  <= mem_rdata;
                        rlast_q  <= (LAST_BEAT == '0);
                        done_q   <= (LAST_BEAT == '0);
                    end else begin
                        lat_q <= lat_q - 1'b1;
                    end
                end
                RBURST: begin
                    if (beat_q == LAST_BEAT) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                        rvalid_q    <= 1'b0;
                        rlast_q     <= 1'b0;
                        done_q      <= 1'b0;
                    end else begin
                        beat_q  <= beat_d;
                        rdata_q <= mem_rdata;
                        rlast_q <= (beat_d == LAST_BEAT);
                        done_q  <= (beat_d == LAST_BEAT);
                    end
                end
                WBURST: begin
                    if (wvalid && beat_q == LAST_BEAT) begin
                        state_q  <= WWAIT;
                        wready_q <= 1'b0;
                        lat_q    <= LAT_INIT;
                        done_q   <= (LATENCY == 1);
                    end else if (wvalid) begin
                        beat_q <= beat_d;
                    end
                end
                WWAIT: begin
                    if (lat_q == LAT_W'(1)) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                        done_q      <= 1'b0;
                    end else begin
                        lat_q  <= lat_q - 1'b1;
                        done_q <= (lat_q == LAT_W'(2));
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign wready    = wready_q;
    assign rdata     = rdata_q;
    assign rvalid    = rvalid_q;
    assign rlast     = rlast_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_block_mem_responder.sv
// tb_block_mem_responder: directed plus randomized block reads/writes checked against a byte-array model.
module tb_block_mem_responder;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [9:0]  req_addr = '0;
    logic [31:0] wdata = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rlast;
    logic        done;
    logic        err;

    int checks = 0;
    int failures = 0;
    bit [7:0] mem_m [1024];

    always #5 clk = ~clk;

    block_mem_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .wdata     (wdata),
        .wvalid    (wvalid),
        .wready    (wready),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .rlast     (rlast),
        .done      (done),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mword(input int a);
        return {mem_m[a+3], mem_m[a+2], mem_m[a+1], mem_m[a]};
    endfunction

    task automatic issue(input bit w, input logic [9:0] a, input bit keep);
        req_write = w;
        req_addr  = a;
        req_valid = 1'b1;
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic rd_burst(input logic [9:0] a);
        int n = 0;
        int blk = int'(a) & 'h3F0;
        while (!rvalid && n < 20) begin
            check("rd_wait_ready", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
            n++;
        end
        check("rd_latency", n, LAT);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rd_valid%0d", i), {31'd0, rvalid}, 32'd1);
            check($sformatf("rd_data%0d", i), rdata, mword(blk + 4*i));
            check($sformatf("rd_last%0d", i), {31'd0, rlast}, (i == 3) ? 32'd1 : 32'd0);
            check($sformatf("rd_done%0d", i), {31'd0, done}, (i == 3) ? 32'd1 : 32'd0);
            if (i == 3) check("rd_err", {31'd0, err}, 32'd0);
            if (i < 3) @(negedge clk);
        end
        @(negedge clk);
        check("rd_end_valid", {31'd0, rvalid}, 32'd0);
        check("rd_end_ready", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic wr_beats(input logic [9:0] a, input int nb, input int gap, input bit rnd_gap);
        int blk = int'(a) & 'h3F0;
        check("wr_wready", {31'd0, wready}, 32'd1);
        for (int i = 0; i < nb; i++) begin
            int g = rnd_gap ? $urandom_range(0, 2) : gap;
            repeat (g) begin
                wvalid = 1'b0;
                wdata  = $urandom;
                @(negedge clk);
                check("wr_gap_wready", {31'd0, wready}, 32'd1);
            end
            wvalid = 1'b1;
            wdata  = (blk == 0 && i == 0 && gap == 0 && !rnd_gap) ? 32'hFF : $urandom;
            if (blk == 0 && gap == 0 && !rnd_gap) wdata = (i == 0) ? 32'hFF : i;
            for (int k = 0; k < 4; k++) mem_m[blk + 4*i + k] = wdata[8*k +: 8];
            @(negedge clk);
        end
        wvalid = 1'b0;
    endtask

    task automatic wr_finish();
        int n = 1;
        check("wr_post_wready", {31'd0, wready}, 32'd0);
        while (!done && n < 20) begin
            check("wr_wait_rvalid", {31'd0, rvalid}, 32'd0);
            @(negedge clk);
            n++;
        end
        check("wr_latency", n, LAT);
        check("wr_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        check("wr_end_done", {31'd0, done}, 32'd0);
        check("wr_end_ready", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int n;
        logic [9:0] a;
        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_wready", {31'd0, wready}, 32'd0);
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_rlast", {31'd0, rlast}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fresh memory read, then the 0xFF,1,2,3 write-back and its read-back.
        issue(0, 10'h000, 0);
        rd_burst(10'h000);
        issue(1, 10'h000, 0);
        wr_beats(10'h000, 4, 0, 0);
        wr_finish();
        issue(0, 10'h000, 0);
        rd_burst(10'h000);
        check("mem_word0", mword(0), 32'h000000FF);

        // Request held through a burst: re-accepted only after done.
        issue(0, 10'h000, 1);
        rd_burst(10'h000);
        @(negedge clk);
        check("held_accept", {31'd0, req_ready}, 32'd0);
        req_valid = 1'b0;
        rd_burst(10'h000);

        // Write beats separated by two idle cycles.
        issue(1, 10'h040, 0);
        wr_beats(10'h040, 4, 2, 0);
        wr_finish();
        issue(0, 10'h040, 0);
        rd_burst(10'h040);
        issue(0, 10'h050, 0);
        rd_burst(10'h050);

        // Write beats offered while idle must not land anywhere.
        repeat (3) begin
            wvalid = 1'b1;
            wdata  = $urandom;
            @(negedge clk);
        end
        wvalid = 1'b0;
        issue(0, 10'h000, 0);
        rd_burst(10'h000);

        // Reset in the middle of a read burst.
        issue(0, 10'h040, 0);
        n = 0;
        while (!rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("mid_rd_rvalid_pre", {31'd0, rvalid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rd_rvalid", {31'd0, rvalid}, 32'd0);
        check("mid_rd_ready", {31'd0, req_ready}, 32'd1);
        check("mid_rd_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset part-way through a write burst keeps the beats already written.
        issue(1, 10'h200, 0);
        wr_beats(10'h200, 2, 0, 1);
        rst_n = 1'b0;
        #1;
        check("mid_wr_wready", {31'd0, wready}, 32'd0);
        check("mid_wr_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(0, 10'h200, 0);
        rd_burst(10'h200);

`ifdef MEM_ALIGN_CHECK_EN
        issue(0, 10'h104, 0);
        check("align_done", {31'd0, done}, 32'd1);
        check("align_err", {31'd0, err}, 32'd1);
        check("align_rvalid", {31'd0, rvalid}, 32'd0);
        @(negedge clk);
        check("align_done_clr", {31'd0, done}, 32'd0);
        check("align_err_clr", {31'd0, err}, 32'd0);
        check("align_ready", {31'd0, req_ready}, 32'd1);
        check("align_rvalid2", {31'd0, rvalid}, 32'd0);
`else
        issue(0, 10'h104, 0);
        rd_burst(10'h104);
`endif

        // Randomized mix of reads and write-backs.
        for (int t = 0; t < 16; t++) begin
            a = 10'($urandom_range(0, 1023));
`ifdef MEM_ALIGN_CHECK_EN
            a[3:0] = 4'h0;
`endif
            if ($urandom_range(0, 1) == 1) begin
                issue(1, a, 0);
                wr_beats(a, 4, 0, 1);
                wr_finish();
            end else begin
                issue(0, a, 0);
                rd_burst(a);
            end
        end
        for (int b = 0; b < 8; b++) begin
            issue(0, 10'(b * 16 + 10'h200), 0);
            rd_burst(10'(b * 16 + 10'h200));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
